// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle; fields whose width parameter is 0 collapse to a single unused bit.
interface logic_axi4_stream_if #(
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1
);
    localparam int unsigned DataW = (TDATA_BYTES > 0) ? TDATA_BYTES * 8 : 1;
    localparam int unsigned KeepW = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
    localparam int unsigned DestW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int unsigned UserW = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int unsigned IdW   = (TID_WIDTH > 0) ? TID_WIDTH : 1;

    logic             tvalid;
    logic             tready;
    logic [DataW-1:0] tdata;
    logic [KeepW-1:0] tkeep;
    logic [KeepW-1:0] tstrb;
    logic             tlast;
    logic [UserW-1:0] tuser;
    logic [DestW-1:0] tdest;
    logic [IdW-1:0]   tid;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
        input  tready
    );
endinterface

// File: rtl/logic_axi4_stream_mux_rr.sv
// N-to-1 AXI4-Stream mux: round-robin arbitration, packet locking on tlast, registered output.
module logic_axi4_stream_mux_rr #(
    parameter int unsigned INPUTS      = 2,
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1,
    parameter int unsigned TLAST       = 1
) (
    input  logic            aclk,
    input  logic            areset_n,
    logic_axi4_stream_if.rx rx [INPUTS],
    logic_axi4_stream_if.tx tx
);
    localparam int unsigned PtrW  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int unsigned DataW = (TDATA_BYTES > 0) ? TDATA_BYTES * 8 : 1;
    localparam int unsigned KeepW = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;
    localparam int unsigned DestW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
    localparam int unsigned UserW = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
    localparam int unsigned IdW   = (TID_WIDTH > 0) ? TID_WIDTH : 1;
    localparam bit          UseLast = (TLAST > 0);

    logic [INPUTS-1:0] rx_valid, rx_last, rx_ready, unused_rx_strb;
    logic [DataW-1:0]  rx_data [INPUTS];
    logic [KeepW-1:0]  rx_keep [INPUTS];
    logic [UserW-1:0]  rx_user [INPUTS];
    logic [DestW-1:0]  rx_dest [INPUTS];
    logic [IdW-1:0]    rx_id   [INPUTS];

    for (genvar g = 0; g < INPUTS; g++) begin : g_rx
        assign rx_valid[g]       = rx[g].tvalid;
        assign rx_last[g]        = rx[g].tlast;
        assign rx_data[g]        = rx[g].tdata;
        assign rx_keep[g]        = rx[g].tkeep;
        assign rx_user[g]        = rx[g].tuser;
        assign rx_dest[g]        = rx[g].tdest;
        assign rx_id[g]          = rx[g].tid;
        assign unused_rx_strb[g] = ^rx[g].tstrb;
        assign rx[g].tready      = rx_ready[g];
    end

    logic            tvalid_q, tvalid_d, locked_q, locked_d, last_q, last_d;
    logic [PtrW-1:0] ptr_q, ptr_d, owner_q, owner_d;
    logic [DataW-1:0] data_q, data_d, sel_data;
    logic [KeepW-1:0] keep_q, keep_d, sel_keep;
    logic [UserW-1:0] user_q, user_d, sel_user;
    logic [DestW-1:0] dest_q, dest_d, sel_dest;
    logic [IdW-1:0]   id_q, id_d, sel_id;
    logic [PtrW-1:0]  grant;
    logic             grant_vld, sel_valid, sel_last, load, hs;

    assign load = !tvalid_q || tx.tready;

    // Two-pass search: channels above ptr first, then wrap around to 0..ptr.
    always_comb begin
        grant     = owner_q;
        grant_vld = locked_q;
        if (!locked_q) begin
            for (int i = 0; i < int'(INPUTS); i++) begin
                if (!grant_vld && rx_valid[i] && (i > int'(ptr_q))) begin
                    grant     = PtrW'(i);
                    grant_vld = 1'b1;
                end
            end
            for (int i = 0; i < int'(INPUTS); i++) begin
                if (!grant_vld && rx_valid[i] && (i <= int'(ptr_q))) begin
                    grant     = PtrW'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rx_ready  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        sel_dest  = '0;
        sel_id    = '0;
        for (int i = 0; i < int'(INPUTS); i++) begin
            if (int'(grant) == i) begin
                sel_valid = rx_valid[i];
                sel_last  = rx_last[i];
                sel_data  = rx_data[i];
                sel_keep  = rx_keep[i];
                sel_user  = rx_user[i];
                sel_dest  = rx_dest[i];
                sel_id    = rx_id[i];
            end
            rx_ready[i] = load && grant_vld && (int'(grant) == i);
        end
    end

    always_comb begin
        hs       = load && grant_vld && sel_valid;
        tvalid_d = load ? hs : tvalid_q;
        ptr_d    = hs ? grant : ptr_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        if (hs && UseLast) begin
            locked_d = !sel_last;
            owner_d  = sel_last ? owner_q : grant;
        end
        data_d = hs ? sel_data : data_q;
        keep_d = hs ? sel_keep : keep_q;
        user_d = hs ? sel_user : user_q;
        dest_d = hs ? sel_dest : dest_q;
        id_d   = hs ? sel_id : id_q;
        last_d = hs ? (sel_last || !UseLast) : last_q;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tvalid_q <= 1'b0;
            ptr_q    <= PtrW'(INPUTS - 1);
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end

    // Payload is qualified by tvalid_q, so it needs no reset.
    always_ff @(posedge aclk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        user_q <= user_d;
        dest_q <= dest_d;
        id_q   <= id_d;
        last_q <= last_d;
    end

    assign tx.tvalid = tvalid_q;
    assign tx.tlast  = UseLast ? last_q : 1'b1;

    if (TDATA_BYTES > 0) begin : g_data
        assign tx.tdata = data_q;
        assign tx.tkeep = keep_q;
        assign tx.tstrb = keep_q;
    end else begin : g_no_data
        assign tx.tdata = '0;
        assign tx.tkeep = '1;
        assign tx.tstrb = '1;
    end
    if (TUSER_WIDTH > 0) begin : g_user
        assign tx.tuser = user_q;
    end else begin : g_no_user
        assign tx.tuser = '0;
    end
    if (TDEST_WIDTH > 0) begin : g_dest
        assign tx.tdest = dest_q;
    end else begin : g_no_dest
        assign tx.tdest = '0;
    end
    if (TID_WIDTH > 0) begin : g_id
        assign tx.tid = id_q;
    end else begin : g_no_id
        assign tx.tid = '0;
    end
endmodule

// File: tb/tb_logic_axi4_stream_mux_rr.sv
// Bench: 4-input packet-locked mux and 2-input per-beat mux, checked against a beat scoreboard.
module tb_logic_axi4_stream_mux_rr;
    typedef logic [11:0] beat_t;  // {last, user, dest, id, data}

    logic aclk = 1'b0;
    logic areset_n;
    always #5 aclk = ~aclk;

    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1))
        rx_a [4] ();
    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1))
        tx_a ();
    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1))
        rx_b [2] ();
    logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1))
        tx_b ();

    logic [3:0] a_valid, a_last, a_ready;
    logic [7:0] a_data [4];
    logic       a_tready, a_bp;
    logic [1:0] b_valid, b_ready;
    logic [7:0] b_data [2];
    logic       b_tready;

    for (genvar g = 0; g < 4; g++) begin : g_src_a
        assign rx_a[g].tvalid = a_valid[g];
        assign rx_a[g].tdata  = a_data[g];
        assign rx_a[g].tkeep  = 1'b1;
        assign rx_a[g].tstrb  = 1'b1;
        assign rx_a[g].tlast  = a_last[g];
        assign rx_a[g].tuser  = a_data[g][0];
        assign rx_a[g].tdest  = a_data[g][1];
        assign rx_a[g].tid    = a_data[g][2];
        assign a_ready[g]     = rx_a[g].tready;
    end
    for (genvar g = 0; g < 2; g++) begin : g_src_b
        assign rx_b[g].tvalid = b_valid[g];
        assign rx_b[g].tdata  = b_data[g];
        assign rx_b[g].tkeep  = 1'b1;
        assign rx_b[g].tstrb  = 1'b1;
        assign rx_b[g].tlast  = 1'b0;
        assign rx_b[g].tuser  = b_data[g][0];
        assign rx_b[g].tdest  = b_data[g][1];
        assign rx_b[g].tid    = b_data[g][2];
        assign b_ready[g]     = rx_b[g].tready;
    end
    assign tx_a.tready = a_tready;
    assign tx_b.tready = b_tready;

    logic_axi4_stream_mux_rr #(
        .INPUTS(4), .TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1), .TLAST(1)
    ) u_dut_a (
        .aclk    (aclk),
        .areset_n(areset_n),
        .rx      (rx_a),
        .tx      (tx_a)
    );

    logic_axi4_stream_mux_rr #(
        .INPUTS(2), .TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1), .TLAST(0)
    ) u_dut_b (
        .aclk    (aclk),
        .areset_n(areset_n),
        .rx      (rx_b),
        .tx      (tx_b)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t qa[$];
    beat_t qb[$];
    int    sent_a [4], lim_a [4], len_a [4], gapat_a [4], gap_a [4];
    logic [7:0] seed_a [4];
    int    sent_b [2], lim_b [2];
    logic  a_stall_prev;
    beat_t a_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l);
        return {l, d[0], d[1], d[2], d};
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            a_valid[i] = (sent_a[i] < lim_a[i]) && (gap_a[i] == 0);
            a_data[i]  = seed_a[i] + 8'(sent_a[i]);
            a_last[i]  = ((sent_a[i] + 1) % len_a[i]) == 0;
        end
        for (int i = 0; i < 2; i++) begin
            b_valid[i] = sent_b[i] < lim_b[i];
            b_data[i]  = {1'(i), 7'(sent_b[i])};
        end
    endtask

    task automatic start_a(input int ch, input int lim, input int len, input logic [7:0] seed);
        sent_a[ch]  = 0;
        lim_a[ch]   = lim;
        len_a[ch]   = len;
        seed_a[ch]  = seed;
        gapat_a[ch] = -1;
        gap_a[ch]   = 0;
    endtask

    // Called just after a falling edge; samples 1 ns before the next rising edge.
    task automatic tick();
        logic [3:0] hs_a;
        logic [1:0] hs_b;
        beat_t      obs;
        #4;
        obs = {tx_a.tlast, tx_a.tuser, tx_a.tdest, tx_a.tid, tx_a.tdata};
        if (a_stall_prev) check("a_stall_hold", {19'd0, tx_a.tvalid, obs}, {19'd0, 1'b1, a_snap});
        if (tx_a.tvalid && !a_tready) check("a_stall_no_ready", 32'(a_ready), 32'd0);
        a_stall_prev = tx_a.tvalid && !a_tready;
        a_snap       = obs;
        if (tx_a.tvalid && a_tready) begin
            check("a_tstrb_tkeep", {30'd0, tx_a.tstrb, tx_a.tkeep}, 32'd3);
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL a_extra_beat: observed %0h expected no beat", obs);
            end else begin
                check("a_beat", 32'(obs), 32'(qa.pop_front()));
            end
        end
        obs = {tx_b.tlast, tx_b.tuser, tx_b.tdest, tx_b.tid, tx_b.tdata};
        if (tx_b.tvalid && b_tready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL b_extra_beat: observed %0h expected no beat", obs);
            end else begin
                check("b_beat", 32'(obs), 32'(qb.pop_front()));
            end
        end
        hs_a = a_valid & a_ready;
        hs_b = b_valid & b_ready;
        @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
            if (hs_a[i]) begin
                sent_a[i]++;
                if (sent_a[i] == gapat_a[i]) gap_a[i] = 2;
            end else if (gap_a[i] > 0) begin
                gap_a[i]--;
            end
        end
        for (int i = 0; i < 2; i++) if (hs_b[i]) sent_b[i]++;
        a_tready = a_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
    endtask

    task automatic run(input string tag, input int exp_ticks);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((qa.size() != 0 || qb.size() != 0) && n < 400);
        if (exp_ticks > 0) check(tag, 32'(n), 32'(exp_ticks));
        else check(tag, 32'(n < 400), 32'd1);
    endtask

    initial begin
        areset_n     = 1'b0;
        a_tready     = 1'b1;
        b_tready     = 1'b1;
        a_bp         = 1'b0;
        a_stall_prev = 1'b0;
        a_snap       = '0;
        for (int i = 0; i < 4; i++) start_a(i, 0, 1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            sent_b[i] = 0;
            lim_b[i]  = 0;
        end
        drive();
        @(negedge aclk);
        @(negedge aclk);
        check("reset_tvalid_a", 32'(tx_a.tvalid), 32'd0);
        check("reset_tvalid_b", 32'(tx_b.tvalid), 32'd0);
        areset_n = 1'b1;
        tick();
        check("idle_tvalid_a", 32'(tx_a.tvalid), 32'd0);
        check("idle_ready_a", 32'(a_ready), 32'd0);
        check("idle_ready_b", 32'(b_ready), 32'd0);

        // Single beat on channel 2 appears one cycle after its handshake.
        start_a(2, 1, 1, 8'hA5);
        qa.push_back(mk(8'hA5, 1'b1));
        drive();
        run("s1_latency", 2);

        @(negedge aclk);
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        a_stall_prev = 1'b0;

        // All four streaming single-beat packets: strict 0,1,2,3 rotation, no bubbles.
        for (int i = 0; i < 4; i++) start_a(i, 3, 1, {2'(i), 6'h00});
        for (int k = 0; k < 12; k++) qa.push_back(mk({2'(k % 4), 6'(k / 4)}, 1'b1));
        drive();
        run("s2_rr_no_idle", 13);

        // Same traffic under random backpressure.
        a_bp = 1'b1;
        for (int i = 0; i < 4; i++) start_a(i, 6, 1, {2'(i), 6'h10});
        for (int k = 0; k < 24; k++) qa.push_back(mk({2'(k % 4), 6'h10 + 6'(k / 4)}, 1'b1));
        drive();
        run("s4_bp_done", 0);
        a_bp = 1'b0;
        tick();
        tick();

        // 3-beat packet on ch0 with a 2-cycle gap must not let ch1 in.
        start_a(0, 3, 3, 8'h00);
        gapat_a[0] = 1;
        start_a(1, 2, 1, 8'h40);
        qa.push_back(mk(8'h00, 1'b0));
        qa.push_back(mk(8'h01, 1'b0));
        qa.push_back(mk(8'h02, 1'b1));
        qa.push_back(mk(8'h40, 1'b1));
        qa.push_back(mk(8'h41, 1'b1));
        drive();
        run("s3_lock", 8);

        // Per-beat build: alternate 0,1 even with tlast inputs low; tx.tlast stays 1.
        for (int i = 0; i < 2; i++) lim_b[i] = 4;
        for (int k = 0; k < 8; k++) qb.push_back(mk({1'(k % 2), 7'(k / 2)}, 1'b1));
        drive();
        run("s5_tlast0", 9);

        // Reset in the middle of a ch3 packet.
        start_a(3, 4, 4, 8'hC0);
        qa.push_back(mk(8'hC0, 1'b0));
        qa.push_back(mk(8'hC1, 1'b0));
        drive();
        tick();
        tick();
        check("s6_pre_valid", 32'(tx_a.tvalid), 32'd1);
        #2;
        areset_n = 1'b0;
        #1;
        check("s6_async_clear", 32'(tx_a.tvalid), 32'd0);
        qa.delete();
        a_stall_prev = 1'b0;
        start_a(0, 1, 1, 8'h0A);
        drive();
        @(negedge aclk);
        areset_n = 1'b1;
        qa.push_back(mk(8'h0A, 1'b1));
        qa.push_back(mk(8'hC2, 1'b0));
        qa.push_back(mk(8'hC3, 1'b1));
        run("s6_restart", 4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
